phi_operand_buffer: RTL

//  Per-edge operand stage feeding the phi/data multiplexer. Buffers values produced by one predecessor

---
 rtl/hdbe_phi_pkg.sv | 17 +
 rtl/phi_operand_ram.sv | 27 ++
 rtl/phi_operand_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/hdbe_phi_pkg.sv
// Shared types and helpers for the phi operand buffer: count width and {valid,data} bundle packing.
package hdbe_phi_pkg;

    localparam int DEF_W = 32;

    typedef logic [DEF_W:0] phi_bundle_t;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The downstream mux ORs its inputs, so an invalid bundle must carry all-zero data.
    function automatic phi_bundle_t pack_bundle(input logic valid, input logic [DEF_W-1:0] data);
        return {valid, data & {DEF_W{valid}}};
    endfunction

endpackage

// File: rtl/phi_operand_ram.sv
// Depth x InBitWidth register array: one synchronous write port, one asynchronous read port.
module phi_operand_ram
    import hdbe_phi_pkg::*;
#(
    parameter int InBitWidth = 32,
    parameter int Depth      = 2,
    localparam int AW        = $clog2(Depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [InBitWidth-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [InBitWidth-1:0] rdata
);

    logic [InBitWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/phi_operand_buffer.sv
// Per-edge operand FIFO feeding the phi mux; presents {valid, valid ? data : 0}.
// Optional same-cycle bypass when empty is enabled by defining PHI_OPERAND_BYPASS_EN.
module phi_operand_buffer
    import hdbe_phi_pkg::*;
#(
    parameter int InBitWidth = 32,
    parameter int Depth      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [InBitWidth-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        consume,
    output logic [InBitWidth:0]         out_bundle,
    output logic [count_w(Depth)-1:0]   count,
    output logic                        err_underflow
);

    localparam int CNT_W = count_w(Depth);
    localparam int PTR_W = $clog2(Depth);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_nxt;
    logic [InBitWidth-1:0] rd_data;
    logic [InBitWidth-1:0] out_data;
    logic                  head_valid;
    logic                  out_valid;
    logic                  byp_take;
    logic                  push;
    logic                  pop;

    phi_operand_ram #(
        .InBitWidth (InBitWidth),
        .Depth      (Depth)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign head_valid = (count != '0);

`ifdef PHI_OPERAND_BYPASS_EN
    // When empty, the incoming value is visible this cycle; if it is consumed now it is never stored.
    assign byp_take  = !head_valid && in_valid && consume;
    assign out_valid = head_valid || in_valid;
    assign out_data  = head_valid ? rd_data : in_data;
`else
    assign byp_take  = 1'b0;
    assign out_valid = head_valid;
    assign out_data  = rd_data;
`endif

    assign push      = in_valid && in_ready && !byp_take;
    assign pop       = consume && head_valid;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // in_ready is registered from next-state count so a full buffer never reopens within the cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            in_ready      <= 1'b1;
            err_underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            in_ready <= (count_nxt != CNT_W'(Depth));
            if (consume && !out_valid) begin
                err_underflow <= 1'b1;
            end
        end
    end

    generate
        if (InBitWidth == DEF_W) begin : g_pkg_pack
            assign out_bundle = pack_bundle(out_valid, out_data);
        end else begin : g_local_pack
            assign out_bundle = {out_valid, out_data & {InBitWidth{out_valid}}};
        end
    endgenerate

endmodule
